// File: rtl/vga_sync_gen_if.sv
// -----------------------------------------------------------------------------
// vga_sync_gen_if
// Bundles the pixel-enable input and all timing outputs of vga_sync_gen so the
// generator and whatever consumes its timing share one connection.
//
// Parameters:
//   COUNT_W       width of the column/row position counters
//
// Signals:
//   i_En          pixel enable (consumer -> generator)
//   o_HSync       horizontal sync at the configured polarity
//   o_VSync       vertical sync at the configured polarity
//   o_Active      high while the current position is visible
//   o_FrameStart  one-cycle pulse when the position becomes (0,0)
//   o_CountCol    current column
//   o_CountRow    current row
//   o_FrameCount  frame counter (constant 0 unless enabled in the generator)
//
// Modports:
//   master        the timing generator
//   slave         the consumer of the timing
// -----------------------------------------------------------------------------
interface vga_sync_gen_if #(
   parameter int COUNT_W = 10
);
   logic               i_En;
   logic               o_HSync;
   logic               o_VSync;
   logic               o_Active;
   logic               o_FrameStart;
   logic [COUNT_W-1:0] o_CountCol;
   logic [COUNT_W-1:0] o_CountRow;
   logic [7:0]         o_FrameCount;

   modport master (
      input  i_En,
      output o_HSync,
      output o_VSync,
      output o_Active,
      output o_FrameStart,
      output o_CountCol,
      output o_CountRow,
      output o_FrameCount
   );

   modport slave (
      output i_En,
      input  o_HSync,
      input  o_VSync,
      input  o_Active,
      input  o_FrameStart,
      input  o_CountCol,
      input  o_CountRow,
      input  o_FrameCount
   );
endinterface

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
// Raster timing generator. Walks a column/row position through
// active -> front porch -> sync -> back porch on both axes, advancing one
// pixel per enabled clock, and decodes sync, visible-area and frame-start
// flags for that position.
//
// Ports:
//   CLK       system clock, all logic on the rising edge
//   i_Reset   synchronous active-high reset, overrides the pixel enable
//   bus       vga_sync_gen_if.master: i_En in; o_HSync, o_VSync, o_Active,
//             o_FrameStart, o_CountCol, o_CountRow, o_FrameCount out
//
// Build option:
//   VGA_SYNC_FRAME_CNT_EN  when defined, o_FrameCount counts frame starts
//                          (wrapping 255 -> 0); otherwise it is tied to 0.
//
// All outputs come from registers loaded on the same edge from the same
// next-position value, so the flags always describe the position currently
// shown on o_CountCol/o_CountRow. Reset parks the position on the last pixel
// of the frame so the first enabled cycle lands on (0,0).
// -----------------------------------------------------------------------------
module vga_sync_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 18,
   parameter int H_PULSE  = 92,
   parameter int H_BACK   = 50,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10,
   parameter int V_PULSE  = 2,
   parameter int V_BACK   = 33,
   parameter int H_POL    = 0,
   parameter int V_POL    = 0,
   parameter int COUNT_W  = 10
) (
   input  logic           CLK,
   input  logic           i_Reset,
   vga_sync_gen_if.master bus
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_PULSE + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_PULSE + V_BACK;

   // Decode comparisons use one extra bit so that thresholds equal to
   // 2^COUNT_W still compare correctly.
   localparam int XW = COUNT_W + 1;

   localparam logic [COUNT_W-1:0] ZERO_C = COUNT_W'(0);
   localparam logic [COUNT_W-1:0] ONE_C  = COUNT_W'(1);
   localparam logic [COUNT_W-1:0] H_LAST = COUNT_W'(H_TOTAL - 1);
   localparam logic [COUNT_W-1:0] V_LAST = COUNT_W'(V_TOTAL - 1);

   localparam logic [XW-1:0] H_ACT_X     = XW'(H_ACTIVE);
   localparam logic [XW-1:0] H_SYNC_LO_X = XW'(H_ACTIVE + H_FRONT);
   localparam logic [XW-1:0] H_SYNC_HI_X = XW'(H_ACTIVE + H_FRONT + H_PULSE - 1);
   localparam logic [XW-1:0] V_ACT_X     = XW'(V_ACTIVE);
   localparam logic [XW-1:0] V_SYNC_LO_X = XW'(V_ACTIVE + V_FRONT);
   localparam logic [XW-1:0] V_SYNC_HI_X = XW'(V_ACTIVE + V_FRONT + V_PULSE - 1);

   localparam logic H_ON = (H_POL != 0) ? 1'b1 : 1'b0;
   localparam logic V_ON = (V_POL != 0) ? 1'b1 : 1'b0;

   // Inclusive window test used for both sync pulses.
   function automatic logic in_window(
      input logic [XW-1:0] pos,
      input logic [XW-1:0] lo,
      input logic [XW-1:0] hi
   );
      in_window = (pos >= lo) && (pos <= hi);
   endfunction

   logic [COUNT_W-1:0] col_r;
   logic [COUNT_W-1:0] row_r;
   logic               hsync_r;
   logic               vsync_r;
   logic               active_r;
   logic               frame_start_r;

   logic [COUNT_W-1:0] col_nxt_s;
   logic [COUNT_W-1:0] row_nxt_s;
   logic [XW-1:0]      col_nxt_x_s;
   logic [XW-1:0]      row_nxt_x_s;
   logic               hsync_nxt_s;
   logic               vsync_nxt_s;
   logic               active_nxt_s;
   logic               origin_s;

   // Next position: column wraps at the end of a line, row steps only on a
   // column wrap and wraps at the end of the frame.
   always_comb begin
      col_nxt_s = col_r;
      row_nxt_s = row_r;
      if (col_r == H_LAST) begin
         col_nxt_s = ZERO_C;
         if (row_r == V_LAST) begin
            row_nxt_s = ZERO_C;
         end else begin
            row_nxt_s = row_r + ONE_C;
         end
      end else begin
         col_nxt_s = col_r + ONE_C;
         row_nxt_s = row_r;
      end
   end

   // Flags decoded from the next position, so they load alongside it.
   always_comb begin
      col_nxt_x_s  = {1'b0, col_nxt_s};
      row_nxt_x_s  = {1'b0, row_nxt_s};
      hsync_nxt_s  = in_window(col_nxt_x_s, H_SYNC_LO_X, H_SYNC_HI_X) ? H_ON : ~H_ON;
      vsync_nxt_s  = in_window(row_nxt_x_s, V_SYNC_LO_X, V_SYNC_HI_X) ? V_ON : ~V_ON;
      active_nxt_s = (col_nxt_x_s < H_ACT_X) && (row_nxt_x_s < V_ACT_X);
      origin_s     = (col_nxt_s == ZERO_C) && (row_nxt_s == ZERO_C);
   end

   // Position and flag registers: reset parks on the last pixel with syncs
   // inactive; a disabled cycle holds everything but clears the start pulse.
   always_ff @(posedge CLK) begin
      if (i_Reset) begin
         col_r         <= H_LAST;
         row_r         <= V_LAST;
         hsync_r       <= ~H_ON;
         vsync_r       <= ~V_ON;
         active_r      <= 1'b0;
         frame_start_r <= 1'b0;
      end else if (bus.i_En) begin
         col_r         <= col_nxt_s;
         row_r         <= row_nxt_s;
         hsync_r       <= hsync_nxt_s;
         vsync_r       <= vsync_nxt_s;
         active_r      <= active_nxt_s;
         frame_start_r <= origin_s;
      end else begin
         frame_start_r <= 1'b0;
      end
   end

`ifdef VGA_SYNC_FRAME_CNT_EN
   logic [7:0] frame_cnt_r;

   // Frame counter steps on the same edge that raises o_FrameStart.
   always_ff @(posedge CLK) begin
      if (i_Reset) begin
         frame_cnt_r <= 8'd0;
      end else if (bus.i_En && origin_s) begin
         frame_cnt_r <= frame_cnt_r + 8'd1;
      end else begin
         frame_cnt_r <= frame_cnt_r;
      end
   end

   assign bus.o_FrameCount = frame_cnt_r;
`else
   assign bus.o_FrameCount = 8'd0;
`endif

   assign bus.o_CountCol   = col_r;
   assign bus.o_CountRow   = row_r;
   assign bus.o_HSync      = hsync_r;
   assign bus.o_VSync      = vsync_r;
   assign bus.o_Active     = active_r;
   assign bus.o_FrameStart = frame_start_r;

endmodule

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
// Directed bench for vga_sync_gen. Instance A uses the default 800x525
// timing; instance B uses the tiny 8x5 active-high timing. Each clock the
// outputs are compared against a small reference model written from the
// timing constants, plus hand-picked spot checks at the boundaries.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

   logic CLK = 1'b0;
   logic rst_a;
   logic rst_b;

   vga_sync_gen_if #(.COUNT_W(10)) bus_a ();
   vga_sync_gen_if #(.COUNT_W(4))  bus_b ();

   vga_sync_gen #(
      .H_ACTIVE(640), .H_FRONT(18), .H_PULSE(92), .H_BACK(50),
      .V_ACTIVE(480), .V_FRONT(10), .V_PULSE(2),  .V_BACK(33),
      .H_POL(0), .V_POL(0), .COUNT_W(10)
   ) u_dut_a (
      .CLK     (CLK),
      .i_Reset (rst_a),
      .bus     (bus_a)
   );

   vga_sync_gen #(
      .H_ACTIVE(4), .H_FRONT(1), .H_PULSE(2), .H_BACK(1),
      .V_ACTIVE(2), .V_FRONT(1), .V_PULSE(1), .V_BACK(1),
      .H_POL(1), .V_POL(1), .COUNT_W(4)
   ) u_dut_b (
      .CLK     (CLK),
      .i_Reset (rst_b),
      .bus     (bus_b)
   );

   always #5 CLK = ~CLK;

`ifdef VGA_SYNC_FRAME_CNT_EN
   localparam logic [31:0] FC_255 = 32'd255;
   localparam logic [31:0] FC_ONE = 32'd1;
`else
   localparam logic [31:0] FC_255 = 32'd0;
   localparam logic [31:0] FC_ONE = 32'd0;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state for instance A.
   int   a_col, a_row, a_fc;
   logic a_hs, a_vs, a_act, a_fs;
   // Reference model state for instance B.
   int   b_col, b_row, b_fc;
   logic b_hs, b_vs, b_act, b_fs;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
      end
   endtask

   // One clock of instance A with the given controls, then model update and compare.
   task automatic step_a(input logic rst, input logic en, input string tag);
      rst_a      = rst;
      bus_a.i_En = en;
      @(posedge CLK);
      #1;
      if (rst) begin
         a_col = 799; a_row = 524; a_fc = 0;
         a_hs = 1'b1; a_vs = 1'b1; a_act = 1'b0; a_fs = 1'b0;
      end else if (en) begin
         if (a_col == 799) begin
            a_col = 0;
            a_row = (a_row == 524) ? 0 : a_row + 1;
         end else begin
            a_col = a_col + 1;
         end
         a_hs  = !(a_col >= 658 && a_col <= 749);
         a_vs  = !(a_row >= 490 && a_row <= 491);
         a_act = (a_col < 640) && (a_row < 480);
         a_fs  = (a_col == 0) && (a_row == 0);
`ifdef VGA_SYNC_FRAME_CNT_EN
         if (a_fs) a_fc = (a_fc + 1) % 256;
`endif
      end else begin
         a_fs = 1'b0;
      end
      check_eq(tag,
         {bus_a.o_CountCol, bus_a.o_CountRow, bus_a.o_HSync, bus_a.o_VSync,
          bus_a.o_Active, bus_a.o_FrameStart, bus_a.o_FrameCount},
         {10'(a_col), 10'(a_row), a_hs, a_vs, a_act, a_fs, 8'(a_fc)});
   endtask

   // One clock of instance B with the given controls, then model update and compare.
   task automatic step_b(input logic rst, input logic en, input string tag);
      rst_b      = rst;
      bus_b.i_En = en;
      @(posedge CLK);
      #1;
      if (rst) begin
         b_col = 7; b_row = 4; b_fc = 0;
         b_hs = 1'b0; b_vs = 1'b0; b_act = 1'b0; b_fs = 1'b0;
      end else if (en) begin
         if (b_col == 7) begin
            b_col = 0;
            b_row = (b_row == 4) ? 0 : b_row + 1;
         end else begin
            b_col = b_col + 1;
         end
         b_hs  = (b_col == 5) || (b_col == 6);
         b_vs  = (b_row == 3);
         b_act = (b_col < 4) && (b_row < 2);
         b_fs  = (b_col == 0) && (b_row == 0);
`ifdef VGA_SYNC_FRAME_CNT_EN
         if (b_fs) b_fc = (b_fc + 1) % 256;
`endif
      end else begin
         b_fs = 1'b0;
      end
      check_eq(tag,
         {12'd0, bus_b.o_CountCol, bus_b.o_CountRow, bus_b.o_HSync, bus_b.o_VSync,
          bus_b.o_Active, bus_b.o_FrameStart, bus_b.o_FrameCount},
         {12'd0, 4'(b_col), 4'(b_row), b_hs, b_vs, b_act, b_fs, 8'(b_fc)});
   endtask

   initial begin
      int n_fs;
      int last_fs;

      rst_b      = 1'b1;
      bus_b.i_En = 1'b0;

      // ---- Instance A: default 800x525 timing ----
      step_a(1'b1, 1'b0, "a_reset");
      step_a(1'b1, 1'b0, "a_reset");
      check_eq("a_rst_col",   32'(bus_a.o_CountCol), 32'd799);
      check_eq("a_rst_row",   32'(bus_a.o_CountRow), 32'd524);
      check_eq("a_rst_hsync", 32'(bus_a.o_HSync),    32'd1);
      check_eq("a_rst_vsync", 32'(bus_a.o_VSync),    32'd1);
      check_eq("a_rst_fc",    32'(bus_a.o_FrameCount), 32'd0);
      step_a(1'b1, 1'b1, "a_reset_over_en");
      check_eq("a_rst_prio_col", 32'(bus_a.o_CountCol), 32'd799);

      step_a(1'b0, 1'b1, "a_first_px");
      check_eq("a_first_col",    32'(bus_a.o_CountCol),   32'd0);
      check_eq("a_first_row",    32'(bus_a.o_CountRow),   32'd0);
      check_eq("a_first_fs",     32'(bus_a.o_FrameStart), 32'd1);
      check_eq("a_first_active", 32'(bus_a.o_Active),     32'd1);
      check_eq("a_first_fc",     32'(bus_a.o_FrameCount), FC_ONE);

      for (int c = 1; c < 800; c++) begin
         step_a(1'b0, 1'b1, "a_line0");
         if (c == 639) check_eq("a_active_639", 32'(bus_a.o_Active), 32'd1);
         if (c == 640) check_eq("a_active_640", 32'(bus_a.o_Active), 32'd0);
         if (c == 657) check_eq("a_hs_657",     32'(bus_a.o_HSync),  32'd1);
         if (c == 658) check_eq("a_hs_658",     32'(bus_a.o_HSync),  32'd0);
         if (c == 749) check_eq("a_hs_749",     32'(bus_a.o_HSync),  32'd0);
         if (c == 750) check_eq("a_hs_750",     32'(bus_a.o_HSync),  32'd1);
      end
      step_a(1'b0, 1'b1, "a_row1");
      check_eq("a_row1_col", 32'(bus_a.o_CountCol), 32'd0);
      check_eq("a_row1_row", 32'(bus_a.o_CountRow), 32'd1);
      check_eq("a_row1_fs",  32'(bus_a.o_FrameStart), 32'd0);

      // 1-of-4 enable duty: 40 enabled cycles, column 0 -> 40 on row 1.
      for (int k = 0; k < 160; k++) begin
         step_a(1'b0, (k % 4) == 0, "a_duty");
      end
      check_eq("a_duty_col", 32'(bus_a.o_CountCol), 32'd40);

      // Advance into the horizontal sync, then reset for a single cycle.
      for (int k = 0; k < 660; k++) begin
         step_a(1'b0, 1'b1, "a_to_sync");
      end
      check_eq("a_sync_col", 32'(bus_a.o_CountCol), 32'd700);
      check_eq("a_sync_hs",  32'(bus_a.o_HSync),     32'd0);
      step_a(1'b1, 1'b1, "a_mid_reset");
      check_eq("a_mid_rst_col", 32'(bus_a.o_CountCol), 32'd799);
      check_eq("a_mid_rst_row", 32'(bus_a.o_CountRow), 32'd524);
      check_eq("a_mid_rst_hs",  32'(bus_a.o_HSync),    32'd1);
      step_a(1'b0, 1'b1, "a_restart");
      check_eq("a_restart_fs", 32'(bus_a.o_FrameStart), 32'd1);
      check_eq("a_restart_col", 32'(bus_a.o_CountCol), 32'd0);
      step_a(1'b0, 1'b0, "a_park");

      // ---- Instance B: 8x5 active-high timing, 40-cycle frame ----
      step_b(1'b1, 1'b0, "b_reset");
      step_b(1'b1, 1'b0, "b_reset");
      check_eq("b_rst_hsync", 32'(bus_b.o_HSync), 32'd0);
      check_eq("b_rst_vsync", 32'(bus_b.o_VSync), 32'd0);
      check_eq("b_rst_col",   32'(bus_b.o_CountCol), 32'd7);

      n_fs    = 0;
      last_fs = 0;
      for (int i = 1; i <= 10250; i++) begin
         step_b(1'b0, 1'b1, "b_run");
         if (bus_b.o_FrameStart === 1'b1) begin
            if (n_fs > 0) check_eq("b_period", 32'(i - last_fs), 32'd40);
            n_fs++;
            last_fs = i;
         end
         if (i == 6)     check_eq("b_hs_col5",  32'(bus_b.o_HSync), 32'd1);
         if (i == 25)    check_eq("b_vs_row3",  32'(bus_b.o_VSync), 32'd1);
         if (i == 10161) check_eq("b_fc_255",   32'(bus_b.o_FrameCount), FC_255);
         if (i == 10201) check_eq("b_fc_wrap",  32'(bus_b.o_FrameCount), 32'd0);
      end
      check_eq("b_fs_count", 32'(n_fs), 32'd257);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
